// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shifter: operation encoding, per-beat
// control sideband, and helpers that place the pipeline registers.
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    // Control that rides with the data through every level. The SRA fill
    // bit is captured once at the input so later levels never re-derive it.
    typedef struct packed {
        op_e  op;
        logic sign;
    } ctrl_t;

    // Number of register stages between input and output.
    function automatic int num_stages(input int shw, input int reg_every);
        return (shw + reg_every - 1) / reg_every;
    endfunction

    // True when a register follows level (1-based) in the chain.
    function automatic bit reg_after(input int level, input int shw, input int reg_every);
        return ((level % reg_every) == 0) || (level == shw);
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the barrel shifter: shifts by the fixed amount AMT
// in the selected mode when en is set, otherwise passes data through.
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  op_e              op,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    // NOTE: result is assigned a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        result = data;
        if (en) begin
            unique case (op)
                OP_SLL:  result = data << AMT;
                OP_SRL:  result = data >> AMT;
                OP_SRA:  result = {{AMT{sign}}, data[WIDTH-1:AMT]};
                OP_ROL:  result = {data[WIDTH-AMT-1:0], data[WIDTH-1:WIDTH-AMT]};
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined four-mode barrel shifter with valid/ready on both sides. Levels run
// MSB first; a register follows every REG_EVERY levels and always the last one.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int REG_EVERY = 2,
    parameter  int TAG_W     = 4,
    localparam int SHW       = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_operand,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shamt;
        ctrl_t            ctrl;
        logic [TAG_W-1:0] tag;
    } payload_t;

    payload_t in_p;
    logic     stall;
    logic     en;

    always_comb begin
        in_p.valid     = in_valid;
        in_p.data      = in_operand;
        in_p.shamt     = in_shamt;
        in_p.ctrl.op   = op_e'(in_op);
        in_p.ctrl.sign = in_operand[WIDTH-1];
        in_p.tag       = in_tag;
    end

    // One global enable: a stalled output freezes every stage, bubbles included,
    // so nothing can be overwritten or duplicated while the consumer waits.
    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = !stall;

    for (genvar j = 1; j <= SHW; j++) begin : gen_lvl
        localparam int K = SHW - j;

        payload_t         d_in;
        payload_t         d_out;
        payload_t         stg;
        logic [WIDTH-1:0] lvl_data;

        if (j == 1) begin : g_first
            assign d_in = in_p;
        end else begin : g_chain
            assign d_in = gen_lvl[j-1].stg;
        end

        shift_level #(
            .WIDTH (WIDTH),
            .AMT   (1 << K)
        ) u_level (
            .data   (d_in.data),
            .en     (d_in.shamt[K]),
            .op     (d_in.ctrl.op),
            .sign   (d_in.ctrl.sign),
            .result (lvl_data)
        );

        always_comb begin
            d_out      = d_in;
            d_out.data = lvl_data;
        end

        if (reg_after(j, SHW, REG_EVERY)) begin : g_reg
            // NOTE: the whole payload is reset, not just valid, because the
            // last stage drives out_result/out_tag and those must read 0 in
            // reset. Sequential state uses non-blocking assignments only.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    stg <= '0;
                end else if (en) begin
                    stg <= d_out;
                end
            end
        end else begin : g_wire
            assign stg = d_out;
        end
    end

    assign out_valid  = gen_lvl[SHW].stg.valid;
    assign out_result = gen_lvl[SHW].stg.data;
    assign out_tag    = gen_lvl[SHW].stg.tag;

    // Shift amount and mode are spent by the time a beat leaves the last level.
    logic unused_tail;
    assign unused_tail = ^{gen_lvl[SHW].stg.shamt, gen_lvl[SHW].stg.ctrl};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed vector table on a 32-bit instance,
// stall/bubble/reset sequences, and random regression on three configurations.
module tb_pipelined_shifter;

    logic clk;
    logic reset;

    logic        iv   [3];
    logic        ordy [3];
    logic [63:0] opnd [3];
    logic [5:0]  sh   [3];
    logic [1:0]  opc  [3];
    logic [3:0]  tg   [3];

    logic        irdy [3];
    logic        ovld [3];
    logic [63:0] res  [3];
    logic [3:0]  otg  [3];

    logic [31:0] r0;
    logic [7:0]  r1;
    logic [63:0] r2;
    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic [3:0]  ot0, ot1, ot2;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam int LAT0 = 3;  // WIDTH=32, REG_EVERY=2
    localparam int LAT1 = 3;  // WIDTH=8,  REG_EVERY=1
    localparam int LAT2 = 1;  // WIDTH=64, REG_EVERY=6

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(32), .REG_EVERY(2), .TAG_W(4)) dut0 (
        .clock(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir0),
        .in_operand(opnd[0][31:0]), .in_shamt(sh[0][4:0]), .in_op(opc[0]), .in_tag(tg[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .out_result(r0), .out_tag(ot0)
    );

    pipelined_shifter #(.WIDTH(8), .REG_EVERY(1), .TAG_W(4)) dut1 (
        .clock(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir1),
        .in_operand(opnd[1][7:0]), .in_shamt(sh[1][2:0]), .in_op(opc[1]), .in_tag(tg[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .out_result(r1), .out_tag(ot1)
    );

    pipelined_shifter #(.WIDTH(64), .REG_EVERY(6), .TAG_W(4)) dut2 (
        .clock(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir2),
        .in_operand(opnd[2]), .in_shamt(sh[2]), .in_op(opc[2]), .in_tag(tg[2]),
        .out_valid(ov2), .out_ready(ordy[2]), .out_result(r2), .out_tag(ot2)
    );

    always_comb begin
        irdy[0] = ir0;  irdy[1] = ir1;  irdy[2] = ir2;
        ovld[0] = ov0;  ovld[1] = ov1;  ovld[2] = ov2;
        res[0]  = {32'b0, r0};
        res[1]  = {56'b0, r1};
        res[2]  = r2;
        otg[0]  = ot0;  otg[1]  = ot1;  otg[2]  = ot2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: mode rules applied to a w-bit value with plain arithmetic.
    function automatic logic [63:0] ref_shift(input logic [63:0] a, input int s,
                                              input logic [1:0] op, input int w);
        logic [63:0] mask;
        logic [63:0] x;
        logic [63:0] r;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        x    = a & mask;
        case (op)
            2'b00:   r = x << s;
            2'b01:   r = x >> s;
            2'b10:   r = x[w-1] ? ((x >> s) | (mask & ~(mask >> s))) : (x >> s);
            default: r = (s == 0) ? x : ((x << s) | (x >> (w - s)));
        endcase
        return r & mask;
    endfunction

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        int          s;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  tag;
    } exp_t;

    // Single beat on the 32-bit instance; checks latency, result and tag.
    task automatic run_vector(input vec_t v);
        int lat;
        iv[0]   = 1'b1;
        ordy[0] = 1'b1;
        opnd[0] = {32'b0, v.a};
        sh[0]   = 6'(v.s);
        opc[0]  = v.op;
        tg[0]   = v.tag;
        @(negedge clk);
        check({v.name, "_in_ready"}, irdy[0], 1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 1;
        while (lat <= 20) begin
            @(negedge clk);
            if (ovld[0]) break;
            @(posedge clk); #1;
            lat++;
        end
        check({v.name, "_latency"}, lat, LAT0);
        check({v.name, "_result"}, res[0], {32'b0, v.exp});
        check({v.name, "_tag"}, otg[0], v.tag);
        @(posedge clk); #1;
    endtask

    // mode 0: random valid/ready; 1: out_ready low in cycles 4..9;
    // 2: in_valid alternating for 10 cycles then high for 10.
    task automatic run_stream(input int d, input int w, input int lat, input int mode,
                              input int n_total, input string nm);
        exp_t        q[$];
        exp_t        e;
        bit          iv_hist[$];
        int          sent = 0, rcvd = 0, c = 0, run = 0, max_run = 0, stalls = 0;
        int          bound;
        bit          prev_stall = 1'b0;
        bit          done = 1'b0;
        bit          v, r, stall_now;
        logic [63:0] prev_res = '0;
        logic [3:0]  prev_tag = '0;
        logic [63:0] mask;
        mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        bound = n_total * 8 + 100;
        while (!done) begin
            case (mode)
                0: begin
                    v = (sent < n_total) && ($urandom_range(0, 3) != 0);
                    r = ($urandom_range(0, 2) != 0);
                end
                1: begin
                    v = (sent < n_total);
                    r = !(c >= 4 && c <= 9);
                end
                default: begin
                    v = (c < 10) ? (c % 2 == 0) : (c < 20);
                    r = 1'b1;
                end
            endcase
            iv[d]   = v;
            ordy[d] = r;
            opnd[d] = {$urandom, $urandom} & mask;
            sh[d]   = 6'($urandom_range(0, w - 1));
            opc[d]  = 2'($urandom_range(0, 3));
            tg[d]   = 4'(sent % 16);
            iv_hist.push_back(v);
            @(negedge clk);
            stall_now = ovld[d] && !ordy[d];
            check({nm, "_in_ready"}, irdy[d], !stall_now);
            if (prev_stall) begin
                check({nm, "_hold_valid"}, ovld[d], 1);
                check({nm, "_hold_result"}, res[d], prev_res);
                check({nm, "_hold_tag"}, otg[d], prev_tag);
            end
            if (mode == 2 && c >= lat)
                check({nm, "_bubble_valid"}, ovld[d], iv_hist[c - lat]);
            if (ovld[d]) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (ovld[d] && ordy[d]) begin
                check({nm, "_expected_beat"}, q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check({nm, "_result"}, res[d], e.res);
                    check({nm, "_tag"}, otg[d], e.tag);
                end
                rcvd++;
            end
            if (iv[d] && irdy[d]) begin
                e.res = ref_shift(opnd[d], int'(sh[d]), opc[d], w);
                e.tag = tg[d];
                q.push_back(e);
                sent++;
            end
            prev_stall = stall_now;
            prev_res   = res[d];
            prev_tag   = otg[d];
            if (stall_now) stalls++;
            @(posedge clk); #1;
            c++;
            if (rcvd >= n_total && sent >= n_total) begin
                done = 1'b1;
            end else if (c > bound) begin
                check({nm, "_timeout_received"}, rcvd, n_total);
                done = 1'b1;
            end
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        check({nm, "_received"}, rcvd, n_total);
        if (mode == 1) check({nm, "_stall_seen"}, stalls > 0, 1);
        if (mode == 2) check({nm, "_consecutive_run"}, max_run, 10);
        repeat (lat + 2) begin
            @(negedge clk);
            check({nm, "_no_extra_beat"}, ovld[d], 0);
            @(posedge clk); #1;
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"sll",      2'b00, 32'h8000_00F1, 4,  4'h1, 32'h0000_0F10};
        vecs[1] = '{"srl",      2'b01, 32'h8000_00F1, 4,  4'h2, 32'h0800_000F};
        vecs[2] = '{"sra",      2'b10, 32'h8000_00F1, 4,  4'h3, 32'hF800_000F};
        vecs[3] = '{"rol",      2'b11, 32'h8000_00F1, 4,  4'h4, 32'h0000_0F18};
        vecs[4] = '{"sll_zero", 2'b00, 32'hDEAD_BEEF, 0,  4'h5, 32'hDEAD_BEEF};
        vecs[5] = '{"srl_zero", 2'b01, 32'hDEAD_BEEF, 0,  4'h6, 32'hDEAD_BEEF};
        vecs[6] = '{"sra_zero", 2'b10, 32'hDEAD_BEEF, 0,  4'h7, 32'hDEAD_BEEF};
        vecs[7] = '{"rol_zero", 2'b11, 32'hDEAD_BEEF, 0,  4'h8, 32'hDEAD_BEEF};
        vecs[8] = '{"sra_max",  2'b10, 32'h8000_0000, 31, 4'h9, 32'hFFFF_FFFF};
        vecs[9] = '{"rol_max",  2'b11, 32'h0000_0001, 31, 4'hA, 32'h8000_0000};

        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; opnd[i] = '0;
            sh[i] = '0;   opc[i] = '0;    tg[i] = '0;
        end
        reset = 1'b1;
        #2;
        check("reset_out_valid", ovld[0], 0);
        check("reset_in_ready", irdy[0], 1);
        check("reset_result", res[0], 0);
        check("reset_tag", otg[0], 0);
        check("reset_out_valid_w8", ovld[1], 0);
        check("reset_out_valid_w64", ovld[2], 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vector(vecs[i]);

        run_stream(0, 32, LAT0, 1, 8, "backpressure");
        run_stream(0, 32, LAT0, 2, 15, "bubbles");

        // Reset with three beats in flight and the first one stalled at the output.
        ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; opnd[0] = 64'(32'h1234_0000 + i); sh[0] = 6'(i + 1);
            opc[0] = 2'b00; tg[0] = 4'(i + 12);
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        check("midrst_pre_valid", ovld[0], 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid", ovld[0], 0);
        check("midrst_in_ready", irdy[0], 1);
        check("midrst_result", res[0], 0);
        check("midrst_tag", otg[0], 0);
        @(posedge clk); #3 reset = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        repeat (8) begin
            @(negedge clk);
            check("midrst_no_stale", ovld[0], 0);
            @(posedge clk); #1;
        end
        check("midrst_idle_ready", irdy[0], 1);

        run_stream(0, 32, LAT0, 0, 300, "rand_w32");
        run_stream(1, 8,  LAT1, 0, 500, "rand_w8");
        run_stream(2, 64, LAT2, 0, 500, "rand_w64");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
